// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared widths and FSM encoding for rom_sequencer
package rom_seq_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_SEND = 2'd2} state_t;
endpackage

// File: rtl/rom_16x8.sv
// rom_16x8: 16-entry x 8-bit asynchronous-read constant ROM
module rom_16x8 (
  input  logic [3:0] i_addr,
  output logic [7:0] o_data
);
  always_comb
    case (i_addr)
      4'd0:    o_data = 8'h1B;
      4'd1:    o_data = 8'h0D;
      4'd2:    o_data = 8'h3A;
      4'd3:    o_data = 8'h47;
      4'd4:    o_data = 8'h52;
      4'd5:    o_data = 8'h6E;
      4'd6:    o_data = 8'h71;
      4'd7:    o_data = 8'h88;
      4'd8:    o_data = 8'h93;
      4'd9:    o_data = 8'hA5;
      4'd10:   o_data = 8'hB6;
      4'd11:   o_data = 8'hC4;
      4'd12:   o_data = 8'hD9;
      4'd13:   o_data = 8'hE2;
      4'd14:   o_data = 8'hF0;
      default: o_data = 8'h1F;
    endcase
endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: streams a burst of ROM words over a valid/ready handshake.
// Define ROM_SEQ_CHECKSUM_EN to XOR-accumulate handshaken words on chk.
module rom_sequencer #(
  parameter int ADDR_W = rom_seq_pkg::ADDR_W,
  parameter int DATA_W = rom_seq_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] chk
);
  import rom_seq_pkg::*;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_done;
  logic [DATA_W-1:0] w_rom;
  logic              w_go;
  rom_16x8 u_rom (.i_addr(r_addr), .o_data(w_rom));
  assign w_go       = (r_state == S_IDLE) && start && !abort;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_state != S_IDLE;
  assign done       = r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_go) begin
            r_addr  <= start_addr;
            r_cnt   <= len;
            r_state <= S_FETCH;
          end
        S_FETCH:
          if (abort) r_state <= S_IDLE;
          else begin
            r_dout  <= w_rom;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        S_SEND:
          // abort wins over a coincident handshake and never yields done
          if (abort) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end else if (dout_ready) begin
            r_valid <= 1'b0;
            if (r_cnt == '0) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_cnt   <= r_cnt - 1'b1;
              r_state <= S_FETCH;
            end
          end
        default: r_state <= S_IDLE;
      endcase
    end
`ifdef ROM_SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] r_chk;
  logic              w_hs;
  assign w_hs = (r_state == S_SEND) && r_valid && dout_ready;
  assign chk  = r_chk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_chk <= '0;
    else if (w_go) r_chk <= '0;
    else if (w_hs) r_chk <= r_chk ^ r_dout;
`else
  assign chk = '0;
`endif
endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: directed self-checking bench for rom_sequencer
module tb_rom_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [3:0] len = '0;
  logic       abort = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] chk;
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] wq[$];
  logic [7:0] chk_done;
`ifdef ROM_SEQ_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  rom_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
    .abort(abort), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .chk(chk)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic idle_outs(input string tag);
    cmp({tag, "_dout"}, dout, 8'h00);
    cmp({tag, "_valid"}, dout_valid, 0);
    cmp({tag, "_busy"}, busy, 0);
    cmp({tag, "_done"}, done, 0);
    cmp({tag, "_chk"}, chk, 8'h00);
  endtask
  task automatic collect(output int nd);
    int n;
    nd = 0;
    wq.delete();
    for (n = 0; n < 100; n++) begin
      if (dout_valid && dout_ready) wq.push_back(dout);
      if (done) begin
        nd++;
        chk_done = chk;
      end
      if (!busy) break;
      tick();
    end
    cmp("timeout", n >= 100, 0);
    tick();
    if (done) nd++;
  endtask
  task automatic burst(input logic [3:0] a, input logic [3:0] l, output int nd);
    start = 1'b1;
    start_addr = a;
    len = l;
    tick();
    start = 1'b0;
    collect(nd);
  endtask
  initial begin
    int nd;
    logic bad;
    tick();
    tick();
    idle_outs("rst");
    rst_n = 1'b1;
    tick();
    // basic two-word burst with exact latency
    dout_ready = 1'b1;
    start = 1'b1;
    start_addr = 4'd0;
    len = 4'd1;
    tick();
    start = 1'b0;
    cmp("t1_busy", busy, 1);
    cmp("t1_fetch_valid", dout_valid, 0);
    tick();
    cmp("t1_v0", dout_valid, 1);
    cmp("t1_w0", dout, 8'h1B);
    tick();
    cmp("t1_gap", dout_valid, 0);
    tick();
    cmp("t1_v1", dout_valid, 1);
    cmp("t1_w1", dout, 8'h0D);
    tick();
    cmp("t1_done", done, 1);
    cmp("t1_busy_end", busy, 0);
    cmp("t1_valid_end", dout_valid, 0);
    tick();
    cmp("t1_done_pulse", done, 0);
    cmp("t1_dout_keep", dout, 8'h0D);
    // address wrap
    burst(4'd15, 4'd1, nd);
    cmp("t2_nw", wq.size(), 2);
    cmp("t2_w0", wq[0], 8'h1F);
    cmp("t2_w1", wq[1], 8'h1B);
    cmp("t2_nd", nd, 1);
    cmp("t2_chk", chk_done, CK ? 8'h04 : 8'h00);
    tick();
    tick();
    cmp("t2_chk_hold", chk, CK ? 8'h04 : 8'h00);
    burst(4'd14, 4'd3, nd);
    cmp("t3_nw", wq.size(), 4);
    cmp("t3_w0", wq[0], 8'hF0);
    cmp("t3_w1", wq[1], 8'h1F);
    cmp("t3_w2", wq[2], 8'h1B);
    cmp("t3_w3", wq[3], 8'h0D);
    cmp("t3_chk", chk_done, CK ? 8'hF9 : 8'h00);
    burst(4'd5, 4'd15, nd);
    cmp("t4_nw", wq.size(), 16);
    cmp("t4_first", wq[0], 8'h6E);
    cmp("t4_last", wq[15], 8'h52);
    cmp("t4_nd", nd, 1);
    cmp("t4_chk", chk_done, CK ? 8'h3E : 8'h00);
    // consumer stall
    dout_ready = 1'b0;
    start = 1'b1;
    start_addr = 4'd0;
    len = 4'd0;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      cmp("t5_hold_v", dout_valid, 1);
      cmp("t5_hold_d", dout, 8'h1B);
      cmp("t5_hold_done", done, 0);
      tick();
    end
    dout_ready = 1'b1;
    cmp("t5_still_v", dout_valid, 1);
    tick();
    cmp("t5_done", done, 1);
    cmp("t5_valid_lo", dout_valid, 0);
    tick();
    cmp("t5_done_pulse", done, 0);
    // abort in second SEND, coincident with a handshake
    start = 1'b1;
    start_addr = 4'd0;
    len = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    cmp("t6_w1", dout, 8'h0D);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp("t6_valid", dout_valid, 0);
    cmp("t6_busy", busy, 0);
    cmp("t6_nodone", done, 0);
    cmp("t6_chk", chk, CK ? 8'h16 : 8'h00);
    start = 1'b1;
    start_addr = 4'd2;
    len = 4'd0;
    tick();
    start = 1'b0;
    cmp("t6_restart", busy, 1);
    cmp("t6_nodone2", done, 0);
    collect(nd);
    cmp("t6_nw", wq.size(), 1);
    cmp("t6_wr", wq[0], 8'h3A);
    cmp("t6_nd", nd, 1);
    cmp("t6_chk2", chk_done, CK ? 8'h3A : 8'h00);
    // abort in IDLE and abort over start
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    cmp("t7_abort_start", busy, 0);
    tick();
    abort = 1'b0;
    cmp("t7_abort_idle", busy, 0);
    cmp("t7_dout_keep", dout, 8'h3A);
    // start while busy is ignored
    dout_ready = 1'b0;
    start = 1'b1;
    start_addr = 4'd3;
    len = 4'd5;
    tick();
    start = 1'b0;
    tick();
    cmp("t8_w0", dout, 8'h47);
    start = 1'b1;
    start_addr = 4'd9;
    len = 4'd2;
    tick();
    start = 1'b0;
    cmp("t8_held", dout, 8'h47);
    dout_ready = 1'b1;
    collect(nd);
    cmp("t8_nw", wq.size(), 6);
    cmp("t8_w1", wq[1], 8'h52);
    cmp("t8_wl", wq[5], 8'h93);
    cmp("t8_nd", nd, 1);
    // asynchronous reset mid-burst
    start = 1'b1;
    start_addr = 4'd0;
    len = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 idle_outs("t9");
    tick();
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done || busy || dout_valid) bad = 1'b1;
    end
    cmp("t9_quiet", bad, 0);
    burst(4'd1, 4'd0, nd);
    cmp("t9_after_w", wq[0], 8'h0D);
    cmp("t9_after_nd", nd, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_sequencer.md
ROM_SEQUENCER -- requirements
Module: rom_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning ROM address width; only value 4 is supported.
REQ-002 SHALL have parameter DATA_W, default 8, meaning ROM word width; only value 8 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  burst request, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first ROM address of burst.
REQ-007 SHALL have port len  input  ADDR_W  burst length minus one (0 = 1 word, 15 = 16 words).
REQ-008 SHALL have port abort  input  1  terminate current burst.
REQ-009 SHALL have port dout  output  DATA_W  registered ROM word.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last word of a burst is accepted.
REQ-014 SHALL have port chk  output  DATA_W  burst checksum (see Configuration).

Function
REQ-015 SHALL implement states IDLE, FETCH, SEND.
REQ-016 IDLE with start=1 and abort=0 SHALL latch start_addr into the address register and len into the remaining-word counter, and go to FETCH.
REQ-017 FETCH SHALL register the ROM word at the current address into dout, set dout_valid=1, and go to SEND, all in one cycle.
REQ-018 SEND SHALL hold dout and dout_valid stable until dout_valid and dout_ready are both high in the same cycle.
REQ-019 On handshake with counter=0, SEND SHALL clear dout_valid, pulse done for the next cycle, and go to IDLE.
REQ-020 On handshake with counter>0, SEND SHALL increment the address modulo 16 (15 wraps to 0), decrement the counter, clear dout_valid, and go to FETCH.
REQ-021 Latency: the first dout_valid SHALL rise 2 cycles after start is sampled; consecutive words SHALL be at most 2 cycles apart when dout_ready is held high.
REQ-022 abort=1 in FETCH or SEND SHALL force IDLE on the next edge, clear dout_valid, and suppress done.
REQ-023 abort=1 in IDLE SHALL have no effect, and abort SHALL take priority over a simultaneous start.
REQ-024 start asserted while busy=1 SHALL be ignored.
REQ-025 A handshake coincident with abort SHALL count as consumed but SHALL NOT produce done.
REQ-026 dout SHALL retain its last value when dout_valid=0.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, address register 0, counter 0, dout 0x00, dout_valid 0, busy 0, done 0, and chk 0x00.
REQ-028 Reset asserted mid-burst SHALL discard the burst, and no done SHALL follow deassertion.

Configuration
REQ-029 With macro ROM_SEQ_CHECKSUM_EN defined, chk SHALL be cleared on burst start and XOR-accumulate every handshaken word; chk SHALL be valid while done is high and held until the next start.
REQ-030 Without ROM_SEQ_CHECKSUM_EN, chk SHALL be tied to 0x00 and no accumulator logic SHALL be present.

Structure
REQ-031 State encoding (IDLE=0, FETCH=1, SEND=2), ADDR_W, and DATA_W SHALL reside in shared package rom_seq_pkg.
REQ-032 The ROM SHALL be the single sub-module rom_16x8, instantiated unmodified, with its address driven directly from the address register.

Verification
REQ-033 start_addr=0, len=1, dout_ready=1 -> dout 0x1B then 0x0D, done pulses once, busy low afterwards.
REQ-034 start_addr=15, len=1 (wrap test) -> dout 0x1F then 0x1B; with ROM_SEQ_CHECKSUM_EN, chk=0x04 at done.
REQ-035 start_addr=0, len=0, dout_ready=0 for 5 cycles then 1 -> dout_valid held with dout=0x1B throughout, done exactly 1 cycle after the handshake.
REQ-036 abort in the second SEND of a len=3 burst -> dout_valid low next cycle, no done, IDLE reached, and a new start is accepted in the following cycle.
REQ-037 rst_n pulsed low mid-burst, and start pulsed while busy -> all outputs at reset values asynchronously, and the start while busy causes no address or counter change.
